mul_pipe_scheduler: RTL and testbench

//  Shares one pipelined 16x16 multiplier among N_REQ requesters. Round-robin

---
 rtl/mul_sched_pkg.sv | 16 +
 rtl/mul_pipe_scheduler_rr_arbiter.sv | 39 +++
 rtl/mul_pipe_scheduler.sv | 124 ++++++++++++
 tb/tb_mul_pipe_scheduler.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_sched_pkg.sv
// Shared sizes and types for the shared-multiplier scheduler: operand/product
// widths, requester tag type and the {valid, tag} delay-line stage.
package mul_sched_pkg;
    localparam int OP_W      = 16;
    localparam int P_W       = 2 * OP_W;
    // Tags are sized for the largest legal requester count so any N_REQ fits.
    localparam int N_REQ_MAX = 8;
    localparam int TAG_W     = $clog2(N_REQ_MAX);

    typedef logic [TAG_W-1:0] tag_t;

    typedef struct packed {
        logic valid;
        tag_t tag;
    } stage_t;
endpackage

// File: rtl/mul_pipe_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first eligible requester strictly after ptr,
// wrapping around so that ptr itself has the lowest priority.
module rr_arbiter
    import mul_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] elig,
    input  tag_t         ptr,
    output logic [N-1:0] grant,
    output tag_t         idx
);
    logic found_s;

    // Two passes: indices above ptr first, then the wrapped-around ones.
    always_comb begin
        grant   = '0;
        idx     = '0;
        found_s = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found_s && elig[i] && (i > int'(ptr))) begin
                found_s  = 1'b1;
                grant[i] = 1'b1;
                idx      = tag_t'(i);
            end else begin
                found_s = found_s;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found_s && elig[i] && (i <= int'(ptr))) begin
                found_s  = 1'b1;
                grant[i] = 1'b1;
                idx      = tag_t'(i);
            end else begin
                found_s = found_s;
            end
        end
    end
endmodule

// File: rtl/mul_pipe_scheduler.sv
// Shares one fixed-latency pipelined multiplier among N_REQ requesters and
// routes each product back to the result slot of the requester that issued it.
module mul_pipe_scheduler
    import mul_sched_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int PIPE_LAT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*OP_W-1:0] req_a,
    input  logic [N_REQ*OP_W-1:0] req_b,
    output logic [N_REQ-1:0]      req_ready,
    output logic [OP_W-1:0]       mul_a,
    output logic [OP_W-1:0]       mul_b,
    input  logic [P_W-1:0]        mul_p,
    output logic [N_REQ-1:0]      res_valid,
    output logic [N_REQ*P_W-1:0]  res_p,
    input  logic [N_REQ-1:0]      res_ack,
    output logic [3:0]            inflight
);
    stage_t [PIPE_LAT-1:0] line_r;
    stage_t                last_s;
    tag_t                  ptr_r;
    tag_t                  gidx_s;
    logic [N_REQ-1:0]      busy_s;
    logic [N_REQ-1:0]      elig_s;
    logic [N_REQ-1:0]      grant_s;
    logic                  issue_s;
    logic [OP_W-1:0]       sel_a_s;
    logic [OP_W-1:0]       sel_b_s;
    logic [OP_W-1:0]       mul_a_r;
    logic [OP_W-1:0]       mul_b_r;
    logic [N_REQ-1:0]      res_valid_r;
    logic [N_REQ*P_W-1:0]  res_p_r;
    logic [3:0]            inflight_r;

    assign last_s = line_r[PIPE_LAT-1];

    // A requester stays busy from issue until its result has been acked.
    always_comb begin
        busy_s = res_valid_r;
        for (int i = 0; i < N_REQ; i++) begin
            for (int s = 0; s < PIPE_LAT; s++) begin
                busy_s[i] = busy_s[i] | (line_r[s].valid & (line_r[s].tag == tag_t'(i)));
            end
        end
    end

    assign elig_s = req_valid & ~busy_s;

    rr_arbiter #(
        .N(N_REQ)
    ) u_arb (
        .elig  (elig_s),
        .ptr   (ptr_r),
        .grant (grant_s),
        .idx   (gidx_s)
    );

    assign issue_s   = |grant_s;
    assign req_ready = grant_s;

    // Operand mux driven by the one-hot grant.
    always_comb begin
        sel_a_s = '0;
        sel_b_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_s[i]) begin
                sel_a_s = req_a[i*OP_W +: OP_W];
                sel_b_s = req_b[i*OP_W +: OP_W];
            end else begin
                sel_a_s = sel_a_s;
                sel_b_s = sel_b_s;
            end
        end
    end

    // Operand register, tag delay line, RR pointer and in-flight count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_a_r    <= '0;
            mul_b_r    <= '0;
            line_r     <= '0;
            ptr_r      <= tag_t'(N_REQ - 1);
            inflight_r <= 4'd0;
        end else begin
            line_r[0] <= '{valid: issue_s, tag: gidx_s};
            for (int s = 1; s < PIPE_LAT; s++) begin
                line_r[s] <= line_r[s-1];
            end
            if (issue_s) begin
                mul_a_r <= sel_a_s;
                mul_b_r <= sel_b_s;
                ptr_r   <= gidx_s;
            end
            inflight_r <= inflight_r + {3'b000, issue_s} - {3'b000, last_s.valid};
        end
    end

    // Result slots: retire sets a slot, ack clears only its valid flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_valid_r <= '0;
            res_p_r     <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (last_s.valid && (last_s.tag == tag_t'(i))) begin
                    res_valid_r[i]         <= 1'b1;
                    res_p_r[i*P_W +: P_W]  <= mul_p;
                end else if (res_ack[i]) begin
                    res_valid_r[i] <= 1'b0;
                end
            end
        end
    end

    assign mul_a     = mul_a_r;
    assign mul_b     = mul_b_r;
    assign res_valid = res_valid_r;
    assign res_p     = res_p_r;
    assign inflight  = inflight_r;
endmodule

// File: tb/tb_mul_pipe_scheduler.sv
// Self-checking bench for mul_pipe_scheduler: directed tables and sequences
// plus random traffic, all compared against an operation-level reference model.
module tb_mul_pipe_scheduler;
    localparam int N  = 4;
    localparam int PL = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_valid;
    logic [63:0]  req_a;
    logic [63:0]  req_b;
    logic [3:0]   req_ready;
    logic [15:0]  mul_a;
    logic [15:0]  mul_b;
    logic [31:0]  mul_p;
    logic [3:0]   res_valid;
    logic [127:0] res_p;
    logic [3:0]   res_ack;
    logic [3:0]   inflight;

    always #5 clk = ~clk;

    mul_pipe_scheduler #(.N_REQ(N), .PIPE_LAT(PL)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .res_valid (res_valid),
        .res_p     (res_p),
        .res_ack   (res_ack),
        .inflight  (inflight)
    );

    // Behavioural multiplier: product of operands registered at edge E is on mul_p before edge E+PL.
    bit [31:0] mp_r [PL-1];
    always @(posedge clk) begin
        mp_r[0] <= 32'(mul_a) * 32'(mul_b);
        for (int s = 1; s < PL - 1; s++) mp_r[s] <= mp_r[s-1];
    end
    assign mul_p = mp_r[PL-2];

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // Reference model: each requester has at most one pending op with a due edge, plus a result slot.
    bit          m_pend [N];
    int          m_due  [N];
    logic [31:0] m_prod [N];
    bit          m_rv   [N];
    logic [31:0] m_res  [N];
    int          m_ptr;
    int          m_g;
    int          m_edge = 0;
    logic [15:0] m_mula;
    logic [15:0] m_mulb;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 1'b0;
            m_rv[i]   = 1'b0;
            m_res[i]  = 32'd0;
        end
        m_ptr  = N - 1;
        m_g    = -1;
        m_mula = 16'd0;
        m_mulb = 16'd0;
    endtask

    function automatic int m_grant();
        for (int k = 1; k <= N; k++) begin
            int c = (m_ptr + k) % N;
            if (req_valid[c] && !m_pend[c] && !m_rv[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [3:0] m_rv_vec();
        logic [3:0] v = 4'b0000;
        for (int i = 0; i < N; i++) v[i] = m_rv[i];
        return v;
    endfunction

    task automatic sample();
        logic [3:0] er  = 4'b0000;
        int         cnt = 0;
        m_g = m_grant();
        if (m_g >= 0) er[m_g] = 1'b1;
        for (int i = 0; i < N; i++) cnt += int'(m_pend[i]);
        chk("req_ready", req_ready, er);
        chk("res_valid", res_valid, m_rv_vec());
        chk("inflight", inflight, cnt);
        for (int i = 0; i < N; i++) chk($sformatf("res_p%0d", i), res_p[i*32 +: 32], m_res[i]);
        chk("mul_a", mul_a, m_mula);
        chk("mul_b", mul_b, m_mulb);
    endtask

    task automatic advance();
        for (int i = 0; i < N; i++) begin
            if (res_ack[i] && m_rv[i]) m_rv[i] = 1'b0;
            if (m_pend[i] && m_due[i] == m_edge) begin
                m_pend[i] = 1'b0;
                m_rv[i]   = 1'b1;
                m_res[i]  = m_prod[i];
            end
        end
        if (m_g >= 0) begin
            m_pend[m_g] = 1'b1;
            m_due[m_g]  = m_edge + PL;
            m_mula      = req_a[m_g*16 +: 16];
            m_mulb      = req_b[m_g*16 +: 16];
            m_prod[m_g] = 32'(m_mula) * 32'(m_mulb);
            m_ptr       = m_g;
        end
        m_edge++;
    endtask

    task automatic half(input logic [3:0] v, input logic [63:0] a, input logic [63:0] b,
                        input logic [3:0] ack);
        req_valid = v;
        req_a     = a;
        req_b     = b;
        res_ack   = ack;
        @(negedge clk);
        sample();
    endtask

    task automatic tick();
        @(posedge clk);
        advance();
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 4'b0000;
        req_a     = 64'd0;
        req_b     = 64'd0;
        res_ack   = 4'b0000;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit          rst;
        logic [3:0]  v;
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  ack;
        logic [3:0]  e_ready;
        logic [3:0]  e_rv;
        logic [3:0]  e_inf;
        logic [31:0] e_p0;
    } vec_t;

    vec_t tbl [17];
    int   gq  [$];

    initial begin
        logic [63:0] a1 = 64'h0000_0000_0000_0003;
        logic [63:0] b1 = 64'h0000_0000_0000_0004;
        logic [63:0] a2 = 64'h0004_0003_0002_0001;
        logic [63:0] b2 = 64'h000A_000A_000A_000A;
        logic [63:0] a4 = 64'h0000_0000_0007_0000;
        logic [63:0] b4 = 64'h0000_0000_0009_0000;

        // Single op (rows 0-6) then four simultaneous requesters (rows 7-16).
        tbl[0]  = '{1'b1, 4'b0001, a1, b1, 4'b0000, 4'b0001, 4'b0000, 4'd0, 32'd0};
        tbl[1]  = '{1'b0, 4'b0000, a1, b1, 4'b0000, 4'b0000, 4'b0000, 4'd1, 32'd0};
        tbl[2]  = '{1'b0, 4'b0000, a1, b1, 4'b0000, 4'b0000, 4'b0000, 4'd1, 32'd0};
        tbl[3]  = '{1'b0, 4'b0000, a1, b1, 4'b0000, 4'b0000, 4'b0000, 4'd1, 32'd0};
        tbl[4]  = '{1'b0, 4'b0000, a1, b1, 4'b0000, 4'b0000, 4'b0000, 4'd1, 32'd0};
        tbl[5]  = '{1'b0, 4'b0000, a1, b1, 4'b0001, 4'b0000, 4'b0001, 4'd0, 32'd12};
        tbl[6]  = '{1'b0, 4'b0000, a1, b1, 4'b0000, 4'b0000, 4'b0000, 4'd0, 32'd12};
        tbl[7]  = '{1'b1, 4'b1111, a2, b2, 4'b0000, 4'b0001, 4'b0000, 4'd0, 32'd0};
        tbl[8]  = '{1'b0, 4'b1111, a2, b2, 4'b0000, 4'b0010, 4'b0000, 4'd1, 32'd0};
        tbl[9]  = '{1'b0, 4'b1111, a2, b2, 4'b0000, 4'b0100, 4'b0000, 4'd2, 32'd0};
        tbl[10] = '{1'b0, 4'b1111, a2, b2, 4'b0000, 4'b1000, 4'b0000, 4'd3, 32'd0};
        tbl[11] = '{1'b0, 4'b1111, a2, b2, 4'b0000, 4'b0000, 4'b0000, 4'd4, 32'd0};
        tbl[12] = '{1'b0, 4'b1111, a2, b2, 4'b0000, 4'b0000, 4'b0001, 4'd3, 32'd10};
        tbl[13] = '{1'b0, 4'b1111, a2, b2, 4'b0000, 4'b0000, 4'b0011, 4'd2, 32'd10};
        tbl[14] = '{1'b0, 4'b1111, a2, b2, 4'b0000, 4'b0000, 4'b0111, 4'd1, 32'd10};
        tbl[15] = '{1'b0, 4'b1111, a2, b2, 4'b1111, 4'b0000, 4'b1111, 4'd0, 32'd10};
        tbl[16] = '{1'b0, 4'b0000, a2, b2, 4'b0000, 4'b0000, 4'b0000, 4'd0, 32'd10};

        do_reset();
        chk("reset_res_valid", res_valid, 4'b0000);
        chk("reset_inflight", inflight, 4'd0);
        chk("reset_res_p", res_p[63:0], 64'd0);

        for (int r = 0; r < 17; r++) begin
            if (tbl[r].rst) do_reset();
            half(tbl[r].v, tbl[r].a, tbl[r].b, tbl[r].ack);
            chk($sformatf("tbl%0d_ready", r), req_ready, tbl[r].e_ready);
            chk($sformatf("tbl%0d_rv", r), res_valid, tbl[r].e_rv);
            chk($sformatf("tbl%0d_inflight", r), inflight, tbl[r].e_inf);
            chk($sformatf("tbl%0d_p0", r), res_p[31:0], tbl[r].e_p0);
            tick();
        end
        for (int i = 0; i < N; i++) chk($sformatf("s2_p%0d", i), res_p[i*32 +: 32], 64'((i + 1) * 10));

        // Fairness: req0 and req2 always valid, acks returned as soon as results appear.
        do_reset();
        for (int c = 0; c < 30; c++) begin
            half(4'b0101, {$urandom, $urandom}, {$urandom, $urandom}, m_rv_vec());
            if (req_ready != 4'b0000) gq.push_back(int'(req_ready));
            tick();
        end
        chk("fair_count", gq.size(), 10);
        for (int k = 0; k < gq.size(); k++) chk($sformatf("fair_seq%0d", k), gq[k], (k % 2 == 0) ? 1 : 4);

        // Held result: 7*9 stays in slot 1 for ten cycles; re-grant only after the ack edge.
        do_reset();
        half(4'b0010, a4, b4, 4'b0000);
        chk("s4_grant", req_ready, 4'b0010);
        tick();
        for (int c = 1; c < 15; c++) begin
            half(4'b0010, a4, b4, 4'b0000);
            if (c >= 5) begin
                chk("s4_hold_ready", req_ready, 4'b0000);
                chk("s4_hold_rv", res_valid, 4'b0010);
                chk("s4_hold_p", res_p[63:32], 64'd63);
            end
            tick();
        end
        half(4'b0010, a4, b4, 4'b0010);
        chk("s4_ack_cycle_ready", req_ready, 4'b0000);
        tick();
        half(4'b0010, a4, b4, 4'b0000);
        chk("s4_regrant", req_ready, 4'b0010);
        chk("s4_p_after_ack", res_p[63:32], 64'd63);
        tick();

        // Reset with three ops in flight.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            half(4'b0111, {$urandom, $urandom}, {$urandom, $urandom}, 4'b0000);
            tick();
        end
        chk("s5_pre_inflight", inflight, 4'd3);
        reset = 1'b1;
        #1;
        chk("s5_async_inflight", inflight, 4'd0);
        chk("s5_async_rv", res_valid, 4'b0000);
        chk("s5_async_mul_a", mul_a, 16'd0);
        do_reset();
        for (int c = 0; c < 8; c++) begin
            half(4'b0000, 64'd0, 64'd0, 4'b0000);
            chk("s5_no_pulse", res_valid, 4'b0000);
            tick();
        end
        half(4'b0001, 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_FFFF, 4'b0000);
        tick();
        for (int c = 0; c < 4; c++) begin
            half(4'b0000, 64'd0, 64'd0, 4'b0000);
            tick();
        end
        half(4'b0000, 64'd0, 64'd0, 4'b0000);
        chk("s5_max_rv", res_valid, 4'b0001);
        chk("s5_max_p", res_p[31:0], 64'hFFFE_0001);
        tick();

        // Spurious ack on an empty slot changes nothing.
        half(4'b0000, 64'd0, 64'd0, 4'b1000);
        chk("s6_rv", res_valid, 4'b0001);
        tick();
        half(4'b0000, 64'd0, 64'd0, 4'b0000);
        chk("s6_rv_after", res_valid, 4'b0001);
        chk("s6_inflight", inflight, 4'd0);
        chk("s6_p0", res_p[31:0], 64'hFFFE_0001);
        tick();

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            half(4'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
